// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. A start pulse in IDLE captures the operands and
// the carry-in. The design then adds one bit per clock, LSB first, through a
// single full-adder stage with a registered carry. After WIDTH clock edges it
// loads the parallel sum and carry-out and raises done for one cycle.
//
// Optional feature: define SERADD_OVF_EN to add the signed-overflow output
// ovf and its supporting carry-into-MSB register c_msb.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, sampled only in IDLE
//   a      in   WIDTH  operand A, captured on acceptance
//   b      in   WIDTH  operand B, captured on acceptance
//   cin    in   1      carry-in, captured on acceptance
//   busy   out  1      high while an addition is in progress
//   done   out  1      one-cycle pulse; sum/cout(/ovf) valid from this cycle
//   sum    out  WIDTH  result register, held until the next completion
//   cout   out  1      carry out of bit WIDTH-1
//   ovf    out  1      two's-complement overflow (SERADD_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             c;
    logic [CNT_W-1:0] cnt;
`ifdef SERADD_OVF_EN
    logic             c_msb;
`endif

    logic             accept;
    logic             last;
    logic             s;
    logic             c_nxt;

    // One full-adder cell: returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic fa_s;
        logic fa_c;
        fa_s = x ^ y ^ ci;
        fa_c = (x & y) | (x & ci) | (y & ci);
        return {fa_c, fa_s};
    endfunction

    assign {c_nxt, s} = full_add(a_sh[0], b_sh[0], c);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_BIT) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Serial datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
`ifdef SERADD_OVF_EN
            c_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh <= a;
                b_sh <= b;
                c    <= cin;
                cnt  <= '0;
            end else if (state == RUN) begin
                // Sum bits enter at the top, so after WIDTH shifts bit 0 sits at bit 0.
                acc  <= {s, acc[WIDTH-1:1]};
                a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                c    <= c_nxt;
                cnt  <= cnt + CNT_W'(1);
                if (last) begin
                    sum  <= {s, acc[WIDTH-1:1]};
                    cout <= c_nxt;
                    done <= 1'b1;
`ifdef SERADD_OVF_EN
                    // c still holds the carry into the MSB on this edge.
                    c_msb <= c;
                    ovf   <= c ^ c_nxt;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH:0] res;
        logic           ovf;
    } sb_entry_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERADD_OVF_EN
    logic             ovf;
`endif

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_done = 0;

    // Reference timing model and scoreboard
    sb_entry_t        sbq[$];
    logic             m_idle = 1'b1;
    int               m_cnt = 0;
    logic             exp_done = 1'b0;
    logic [WIDTH-1:0] exp_sum = '0;
    logic             exp_cout = 1'b0;
    logic             exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic sb_entry_t model_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic ci);
        sb_entry_t e;
        e.res = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        e.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // Advance one clock and check every output against the model.
    task automatic tick();
        logic             s_rst;
        logic             s_start;
        logic [WIDTH-1:0] s_a;
        logic [WIDTH-1:0] s_b;
        logic             s_cin;
        sb_entry_t        e;
        s_rst   = rst_n;
        s_start = start;
        s_a     = a;
        s_b     = b;
        s_cin   = cin;
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        if (!s_rst) begin
            m_idle   = 1'b1;
            m_cnt    = 0;
            sbq.delete();
            exp_sum  = '0;
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
        end else if (m_idle) begin
            if (s_start) begin
                sbq.push_back(model_add(s_a, s_b, s_cin));
                m_idle = 1'b0;
                m_cnt  = WIDTH;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_idle   = 1'b1;
                exp_done = 1'b1;
                if (sbq.size() == 0) begin
                    chk("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    e        = sbq.pop_front();
                    exp_sum  = e.res[WIDTH-1:0];
                    exp_cout = e.res[WIDTH];
                    exp_ovf  = e.ovf;
                end
            end
        end
        if (done === 1'b1) n_done++;
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("done", 32'(done), 32'(exp_done));
        chk("sum", 32'(sum), 32'(exp_sum));
        chk("cout", 32'(cout), 32'(exp_cout));
        chk("busy_and_done", 32'(busy & done), 32'd0);
`ifdef SERADD_OVF_EN
        chk("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
        a     = x;
        b     = y;
        cin   = ci;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~x;
        b     = ~y;
        cin   = ~ci;
        repeat (WIDTH + 2) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        // Reset then idle
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();

        // Basic addition, then boundary cases
        run_op(8'h5A, 8'h3C, 1'b0);
        chk("sum_5a_3c", 32'(sum), 32'h96);
        run_op(8'hFF, 8'h01, 1'b0);
        chk("cout_ff_01", 32'(cout), 32'd1);
        run_op(8'h80, 8'h80, 1'b0);
        run_op(8'h00, 8'h00, 1'b1);
        chk("sum_cin_only", 32'(sum), 32'h01);
        run_op(8'hFF, 8'hFF, 1'b1);

        // start during RUN is ignored
        n_done = 0;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (WIDTH + 3) tick();
        chk("ignored_start_sum", 32'(sum), 32'h46);
        chk("ignored_start_dones", 32'(n_done), 32'd1);

        // Reset in the middle of RUN abandons the operation
        n_done = 0;
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("rst_run_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2 * WIDTH) tick();
        chk("rst_run_no_done", 32'(n_done), 32'd0);

        // start held high: one result every WIDTH+1 cycles
        n_done = 0;
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        repeat (5 * (WIDTH + 1)) tick();
        chk("held_start_dones", 32'(n_done), 32'd5);
        chk("held_start_sum", 32'(sum), 32'h03);

        // Random sweep with start held high, operands changing every cycle
        n_done = 0;
        repeat (1000 * (WIDTH + 1)) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (WIDTH + 2) tick();
        chk("random_dones", 32'(n_done), 32'd1000);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
